pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Central pipeline controller that sequences the PC register and the IF/ID pipeline registers.
- Merges redirect requests from the execute stage and the interrupt controller into one jump_flag_o/jump_addr_o pair for the PC register.
- Merges stall requests, including its own memory-wait state machine, into one hold_flag_o.
- Holds redirects that arrive during a memory stall, raises a bus timeout, and keeps a stall performance counter.

Parameters:
- ADDR_W, 32, instruction address width (matches InstAddrBus)
- MEM_TIMEOUT, 16, cycles in MEM_WAIT before the bus is declared hung (range 2..255)
- CNT_W, 16, width of the stall performance counter

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- jump_flag_ex_i  in  1  execute-stage redirect request
- jump_addr_ex_i  in  ADDR_W  execute-stage redirect target
- hold_ex_i  in  1  execute multi-cycle op busy (divider)
- int_assert_i  in  1  interrupt-controller redirect request, one-cycle pulse
- int_addr_i  in  ADDR_W  trap vector
- mem_req_i  in  1  load/store issued to bus this cycle
- mem_ack_i  in  1  bus completed the access
- jump_flag_o  out  1  PC load enable
- jump_addr_o  out  ADDR_W  PC load value
- hold_flag_o  out  3  0=none, 1=hold PC, 2=hold PC+IF, 3=hold PC+IF+ID
- bus_err_o  out  1  one-cycle pulse on bus timeout
- stall_cnt_o  out  CNT_W  saturating count of cycles with hold_flag_o != 0

Behaviour:
- Reset (rst=0, async) values:
  - FSM = RUN.
  - pend_valid=0, pend_addr=0, timeout counter=0.
  - stall_cnt_o=0, bus_err_o=0.
  - jump_flag_o=0, jump_addr_o=0, hold_flag_o=0.
- Reset mid-MEM_WAIT discards any pending redirect; no jump is issued after reset release.
- jump_flag_o, jump_addr_o and hold_flag_o are combinational from inputs and state (zero-latency redirect; the PC register loads on the next edge). bus_err_o and stall_cnt_o are registered.
- Priority in RUN: int_assert_i > jump_flag_ex_i. Both set in one cycle -> jump_addr_o=int_addr_i.
- RUN:
  - Redirect present -> jump_flag_o=1; hold_flag_o=0 unless hold_ex_i.
  - hold_ex_i=1 -> hold_flag_o=3.
  - mem_req_i=1 and mem_ack_i=0 -> hold_flag_o=3 this cycle; next state MEM_WAIT; timeout counter cleared.
  - mem_req_i=1 and mem_ack_i=1 -> no stall; stay in RUN.
- MEM_WAIT:
  - hold_flag_o=3 every cycle; jump_flag_o=0.
  - Incoming int_assert_i latches pend_addr=int_addr_i, pend_valid=1 (overwrites a pending ex jump).
  - Incoming jump_flag_ex_i latches only if pend_valid=0 or the pending entry is not an interrupt.
  - Counter increments each cycle.
- MEM_WAIT exit:
  - mem_ack_i=1 -> in that same cycle hold_flag_o=0 and, if pend_valid, jump_flag_o=1 with jump_addr_o=pend_addr. pend_valid clears; next state RUN.
  - A redirect arriving in the ack cycle follows the same priority; an interrupt beats the pending entry.
  - Counter reaches MEM_TIMEOUT-1 without ack -> bus_err_o=1 next cycle for 1 cycle. Return to RUN, release hold, issue any pending redirect as in the ack case.
- hold_ex_i in MEM_WAIT has no extra effect (already 3). On exit to RUN, hold_flag_o falls to 3 if hold_ex_i is still set, else 0.
- stall_cnt_o increments on every cycle with hold_flag_o!=0 and saturates at all-ones (no wrap).
- hold_flag_o values 1 and 2 are reserved and never driven by this version.

Test Plan:
- Reset then idle: after rst rises, hold_flag_o=0, jump_flag_o=0, stall_cnt_o=0. Assert rst low mid-cycle -> outputs 0 immediately, without waiting for a clock edge.
- Simultaneous redirect: int_assert_i=1 with int_addr_i=0x00000010 and jump_flag_ex_i=1 with jump_addr_ex_i=0x00000400 in RUN -> same cycle jump_flag_o=1, jump_addr_o=0x10.
- Memory stall with pending jump: mem_req_i=1, ack after 4 cycles; jump_ex to 0x200 on stall cycle 2.
  - Required: hold_flag_o=3 for 4 cycles, jump_flag_o=0 meanwhile.
  - Ack cycle: hold_flag_o=0, jump_flag_o=1, jump_addr_o=0x200.
  - stall_cnt_o=4.
- Interrupt overrides pending: in MEM_WAIT, ex jump 0x200 then int 0x10 -> on ack, jump_addr_o=0x10 and only one jump pulse.
- Timeout: MEM_TIMEOUT=16, mem_req_i=1, ack never arrives -> bus_err_o pulses once 16 cycles after entry, hold released, FSM returns to RUN.
- Counter saturation: CNT_W=4, hold_ex_i held for 20 cycles -> stall_cnt_o stops at 15; reset mid-MEM_WAIT clears the pending entry (no jump after release).

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline controller merging redirects and stalls for the PC and IF/ID registers.
//   clk            system clock
//   rst            asynchronous active-low reset
//   jump_flag_ex_i execute-stage redirect request, jump_addr_ex_i its target
//   hold_ex_i      execute multi-cycle op busy
//   int_assert_i   interrupt redirect pulse, int_addr_i trap vector
//   mem_req_i      load/store issued this cycle, mem_ack_i bus completed access
//   jump_flag_o    PC load enable, jump_addr_o PC load value (combinational)
//   hold_flag_o    0=none, 3=hold PC+IF+ID (combinational)
//   bus_err_o      one-cycle pulse on bus timeout (registered)
//   stall_cnt_o    saturating count of held cycles (registered)
module pipe_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jump_flag_ex_i,
    input  logic [ADDR_W-1:0] jump_addr_ex_i,
    input  logic              hold_ex_i,
    input  logic              int_assert_i,
    input  logic [ADDR_W-1:0] int_addr_i,
    input  logic              mem_req_i,
    input  logic              mem_ack_i,
    output logic              jump_flag_o,
    output logic [ADDR_W-1:0] jump_addr_o,
    output logic [2:0]        hold_flag_o,
    output logic              bus_err_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);
    typedef enum logic {RUN, MEM_WAIT} state_t;
    localparam logic [7:0] T_LAST = 8'(MEM_TIMEOUT - 1);
    state_t            state;
    logic              pend_valid, pend_int;
    logic [ADDR_W-1:0] pend_addr;
    logic [7:0]        tcnt;
    logic              timeout, exit_wait, ex_take, nv, ni;
    logic [ADDR_W-1:0] na;
    always_comb begin
        timeout     = tcnt == T_LAST;
        exit_wait   = state == MEM_WAIT && (mem_ack_i || timeout);
        // an ex jump may replace a pending ex jump but never a pending interrupt
        ex_take     = jump_flag_ex_i && !(pend_valid && pend_int);
        nv          = int_assert_i || jump_flag_ex_i || pend_valid;
        ni          = int_assert_i || (!ex_take && pend_int);
        na          = int_assert_i ? int_addr_i : ex_take ? jump_addr_ex_i : pend_addr;
        // outputs are gated by rst so they drop as soon as reset asserts
        jump_flag_o = rst && (state == RUN ? (int_assert_i || jump_flag_ex_i) : (exit_wait && nv));
        jump_addr_o = jump_flag_o ? na : '0;
        hold_flag_o = rst && ((state == MEM_WAIT && !exit_wait) || hold_ex_i ||
                              (state == RUN && mem_req_i && !mem_ack_i)) ? 3'd3 : 3'd0;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= RUN;
            pend_valid  <= 1'b0;
            pend_int    <= 1'b0;
            pend_addr   <= '0;
            tcnt        <= '0;
            bus_err_o   <= 1'b0;
            stall_cnt_o <= '0;
        end else begin
            bus_err_o <= state == MEM_WAIT && !mem_ack_i && timeout;
            if (hold_flag_o != 3'd0 && !(&stall_cnt_o))
                stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            tcnt <= state == MEM_WAIT ? tcnt + 8'd1 : 8'd0;
            if (state == RUN) begin
                state <= (mem_req_i && !mem_ack_i) ? MEM_WAIT : RUN;
            end else if (exit_wait) begin
                state      <= RUN;
                pend_valid <= 1'b0;
                pend_int   <= 1'b0;
            end else begin
                pend_valid <= nv;
                pend_int   <= ni;
                pend_addr  <= na;
            end
        end
    end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: scoreboard bench for pipe_ctrl with directed vectors.
module tb_pipe_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        jump_flag_ex_i = 1'b0, hold_ex_i = 1'b0, int_assert_i = 1'b0;
    logic        mem_req_i = 1'b0, mem_ack_i = 1'b0;
    logic [31:0] jump_addr_ex_i = '0, int_addr_i = '0;
    logic        jump_flag_o, bus_err_o;
    logic [31:0] jump_addr_o;
    logic [2:0]  hold_flag_o;
    logic [3:0]  stall_cnt_o;
    int          checks = 0, passes = 0;

    typedef struct {
        string       tag;
        logic        jf;
        logic [31:0] ja;
        logic [2:0]  h;
        logic        be;
        logic [3:0]  sc;
    } exp_t;
    exp_t q[$];

    pipe_ctrl #(.ADDR_W(32), .MEM_TIMEOUT(16), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .jump_flag_ex_i(jump_flag_ex_i), .jump_addr_ex_i(jump_addr_ex_i),
        .hold_ex_i(hold_ex_i), .int_assert_i(int_assert_i), .int_addr_i(int_addr_i),
        .mem_req_i(mem_req_i), .mem_ack_i(mem_ack_i),
        .jump_flag_o(jump_flag_o), .jump_addr_o(jump_addr_o), .hold_flag_o(hold_flag_o),
        .bus_err_o(bus_err_o), .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (jump_flag_o === e.jf && jump_addr_o === e.ja && hold_flag_o === e.h &&
                bus_err_o === e.be && stall_cnt_o === e.sc)
                passes++;
            else
                $display("FAIL %s: got jf=%b ja=%h h=%0d be=%b sc=%0d, expected jf=%b ja=%h h=%0d be=%b sc=%0d",
                         e.tag, jump_flag_o, jump_addr_o, hold_flag_o, bus_err_o, stall_cnt_o,
                         e.jf, e.ja, e.h, e.be, e.sc);
        end
    end

    task automatic push(input string tag, input logic jf, input logic [31:0] ja,
                        input logic [2:0] h, input logic be, input logic [3:0] sc);
        exp_t e;
        e.tag = tag; e.jf = jf; e.ja = ja; e.h = h; e.be = be; e.sc = sc;
        q.push_back(e);
    endtask

    task automatic cyc(input string tag, input logic ia, jx, hx, mr, ma,
                       input logic [31:0] iaddr, jaddr,
                       input logic ejf, input logic [31:0] eja, input logic [2:0] eh,
                       input logic ebe, input logic [3:0] esc);
        int_assert_i = ia; jump_flag_ex_i = jx; hold_ex_i = hx;
        mem_req_i = mr; mem_ack_i = ma; int_addr_i = iaddr; jump_addr_ex_i = jaddr;
        push(tag, ejf, eja, eh, ebe, esc);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        int_assert_i = 0; jump_flag_ex_i = 0; hold_ex_i = 0;
        mem_req_i = 0; mem_ack_i = 0; int_addr_i = '0; jump_addr_ex_i = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        cyc("reset_idle", 0,0,0,0,0, 0,0,         0,0,3'd0,0,4'd0);
        cyc("simul_redirect", 1,1,0,0,0, 32'h10,32'h400, 1,32'h10,3'd0,0,4'd0);
        cyc("ex_redirect", 0,1,0,0,0, 0,32'h400,  1,32'h400,3'd0,0,4'd0);
        cyc("ex_jump_hold", 0,1,1,0,0, 0,32'h80,  1,32'h80,3'd3,0,4'd0);
        cyc("after_hold", 0,0,0,0,0, 0,0,         0,0,3'd0,0,4'd1);
        cyc("mem_req_ack", 0,0,0,1,1, 0,0,        0,0,3'd0,0,4'd1);
        do_reset();
        // memory stall with pending ex jump
        cyc("stall_c0", 0,0,0,1,0, 0,0,           0,0,3'd3,0,4'd0);
        cyc("stall_c1_jx", 0,1,0,0,0, 0,32'h200,  0,0,3'd3,0,4'd1);
        cyc("stall_c2", 0,0,0,0,0, 0,0,           0,0,3'd3,0,4'd2);
        cyc("stall_c3", 0,0,0,0,0, 0,0,           0,0,3'd3,0,4'd3);
        cyc("stall_ack", 0,0,0,0,1, 0,0,          1,32'h200,3'd0,0,4'd4);
        cyc("stall_after", 0,0,0,0,0, 0,0,        0,0,3'd0,0,4'd4);
        // interrupt overrides pending ex jump, later ex cannot replace it
        cyc("ovr_c0", 0,0,0,1,0, 0,0,             0,0,3'd3,0,4'd4);
        cyc("ovr_jx", 0,1,0,0,0, 0,32'h200,       0,0,3'd3,0,4'd5);
        cyc("ovr_int", 1,0,0,0,0, 32'h10,0,       0,0,3'd3,0,4'd6);
        cyc("ovr_jx2", 0,1,0,0,0, 0,32'h300,      0,0,3'd3,0,4'd7);
        cyc("ovr_ack", 0,0,0,0,1, 0,0,            1,32'h10,3'd0,0,4'd8);
        cyc("ovr_after", 0,0,0,0,0, 0,0,          0,0,3'd0,0,4'd8);
        // interrupt arriving in the ack cycle beats the pending entry
        cyc("ackint_c0", 0,0,0,1,0, 0,0,          0,0,3'd3,0,4'd8);
        cyc("ackint_jx", 0,1,0,0,0, 0,32'h200,    0,0,3'd3,0,4'd9);
        cyc("ackint_ack", 1,0,0,0,1, 32'h44,0,    1,32'h44,3'd0,0,4'd10);
        cyc("ackint_after", 0,0,0,0,0, 0,0,       0,0,3'd0,0,4'd10);
        do_reset();
        // timeout: 16 held cycles, release with pending jump, then bus_err pulse
        cyc("to_c0", 0,0,0,1,0, 0,0,              0,0,3'd3,0,4'd0);
        for (int k = 1; k <= 15; k++)
            cyc("to_wait", 0,(k == 3),0,0,0, 0,32'h500, 0,0,3'd3,0,4'(k));
        cyc("to_release", 0,0,0,0,0, 0,0,         1,32'h500,3'd0,0,4'd15);
        cyc("to_bus_err", 0,0,0,0,0, 0,0,         0,0,3'd0,1,4'd15);
        cyc("to_err_clear", 0,0,0,0,0, 0,0,       0,0,3'd0,0,4'd15);
        do_reset();
        // stall counter saturation
        for (int i = 0; i < 20; i++)
            cyc("sat_hold", 0,0,1,0,0, 0,0,       0,0,3'd3,0,4'((i > 15) ? 15 : i));
        cyc("sat_idle", 0,0,0,0,0, 0,0,           0,0,3'd0,0,4'd15);
        do_reset();
        // asynchronous reset mid MEM_WAIT drops the pending jump
        cyc("mr_c0", 0,0,0,1,0, 0,0,              0,0,3'd3,0,4'd0);
        cyc("mr_jx", 0,1,0,0,0, 0,32'h600,        0,0,3'd3,0,4'd1);
        idle_inputs();
        #2 rst = 1'b0;
        push("async_rst", 0,0,3'd0,0,4'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc("post_rst_ack", 0,0,0,0,1, 0,0,       0,0,3'd0,0,4'd0);
        cyc("post_rst_idle", 0,0,0,0,0, 0,0,      0,0,3'd0,0,4'd0);
        @(negedge clk);
        #1;
        checks++;
        if (q.size() == 0) passes++;
        else $display("FAIL drain: %0d entries left, expected 0", q.size());
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
